aes_round_controller: RTL and testbench

Iterative AES-128/192/256 encryption sequencer that runs one cipher round per clock over a single shared round datapath (sub_bytes -> shift_rows -> mix_columns -> add_round_key). It accepts a plaintext block with a valid/ready handshake and requests round keys by index from an external key-schedule store. It returns the ciphertext with a valid/ack handshake. It sits between the block-level host interface and the combinational round primitives.

---
 rtl/aes_round_controller.sv | 141 ++++++++++++++
 tb/tb_aes_round_controller.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_controller.sv
// Iterative AES-128/192/256 encryption sequencer: one cipher round per clock over a
// shared round datapath, round keys fetched by index from an external async-read store.
module aes_round_controller #(
  parameter int NR = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  output logic         o_ready,
  input  logic [127:0] i_plaintext,
  output logic [3:0]   o_round_idx,
  input  logic [127:0] i_round_key,
  output logic [127:0] o_ciphertext,
  output logic         o_valid,
  input  logic         i_ack,
  output logic         o_busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_controller: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_IDX     = 4'(NR);
  localparam logic [3:0] LAST_ROUND = 4'(NR - 1);

  // Entry b of the S-box sits at bits [8*(255-b) +: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] sr_w, mc_w;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] res;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return res;
  endfunction

  // Byte (row r, column c) lives at index 4c+r; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return res;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = xtime(a[r] ^ a[(r+1)%4]) ^ a[(r+1)%4]
                                  ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return res;
  endfunction

  assign sr_w = shift_rows(sub_bytes(state_q));
  assign mc_w = mix_columns(sr_w);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      ct_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    ct_d        = ct_q;
    o_round_idx = 4'd0;
    case (fsm_q)
      IDLE: begin
        if (i_start) begin
          state_d = i_plaintext;
          cnt_d   = 4'd0;
          fsm_d   = INIT;
        end
      end
      INIT: begin
        state_d = state_q ^ i_round_key;
        cnt_d   = 4'd1;
        fsm_d   = ROUND;
      end
      ROUND: begin
        o_round_idx = cnt_q;
        state_d     = mc_w ^ i_round_key;
        cnt_d       = cnt_q + 4'd1;
        if (cnt_q == LAST_ROUND) fsm_d = FINAL;
      end
      FINAL: begin
        // Last round skips mix_columns and writes straight to the output register.
        o_round_idx = NR_IDX;
        ct_d        = sr_w ^ i_round_key;
        fsm_d       = DONE;
      end
      DONE: begin
        if (i_ack) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign o_ready      = (fsm_q == IDLE);
  assign o_valid      = (fsm_q == DONE);
  assign o_busy       = (fsm_q == INIT) || (fsm_q == ROUND) || (fsm_q == FINAL);
  assign o_ciphertext = ct_q;

endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller: NR=10 and NR=14 instances side by side, checked every
// cycle against a transaction-timing model built on a from-first-principles AES reference.
module tb_aes_round_controller;

  localparam logic [127:0] APPB_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] APPB_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] APPB_INIT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] APPB_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] APPB_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C1_PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] C3_KEY    =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT     = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         ack;
  logic [127:0] pt;
  logic         rdy  [2];
  logic         vld  [2];
  logic         bsy  [2];
  logic [3:0]   idx  [2];
  logic [127:0] ct   [2];
  logic [127:0] rkey [2];

  logic [127:0] rk [2][16];
  logic [7:0]   sbox_t [256];

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;
  int   first [2];
  logic [3:0] seq [16];

  logic         m_act [2];
  int           m_t   [2];
  logic [127:0] m_exp [2];
  logic [127:0] m_ct  [2];

  assign rkey[0] = rk[0][idx[0]];
  assign rkey[1] = rk[1][idx[1]];

  aes_round_controller #(.NR(10)) dut10 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_ready(rdy[0]),
    .i_plaintext(pt), .o_round_idx(idx[0]), .i_round_key(rkey[0]),
    .o_ciphertext(ct[0]), .o_valid(vld[0]), .i_ack(ack), .o_busy(bsy[0])
  );

  aes_round_controller #(.NR(14)) dut14 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_ready(rdy[1]),
    .i_plaintext(pt), .o_round_idx(idx[1]), .i_round_key(rkey[1]),
    .o_ciphertext(ct[1]), .o_valid(vld[1]), .i_ack(ack), .o_busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int nr_of(input int d);
    return (d == 0) ? 10 : 14;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand(input int d, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r <= nr; r++) rk[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] p, input int d);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    int nr = nr_of(d);
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rk[d][0][127-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < nr)
            s[4*c+r] = gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4])
                       ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[d][rnd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string name, input int nr, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (NR=%0d): actual=%h required=%h", name, nr, act, exp);
    end
  endtask

  // Timing model: accept while idle, NR+1 busy cycles with key index = cycles since accept,
  // then the block's ciphertext is presented until acked.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d] <= 1'b0;
        m_t[d]   <= 0;
        m_exp[d] <= '0;
        m_ct[d]  <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!m_act[d]) begin
          if (start) begin
            m_act[d] <= 1'b1;
            m_t[d]   <= 0;
            m_exp[d] <= aes_ref(pt, d);
          end
        end else if (m_t[d] <= nr_of(d)) begin
          if (m_t[d] == nr_of(d)) m_ct[d] <= m_exp[d];
          m_t[d] <= m_t[d] + 1;
        end else if (ack) begin
          m_act[d] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("ready", nr_of(d), 128'(rdy[d]), 128'(!m_act[d]));
        chk("busy", nr_of(d), 128'(bsy[d]), 128'(m_act[d] && m_t[d] <= nr_of(d)));
        chk("valid", nr_of(d), 128'(vld[d]), 128'(m_act[d] && m_t[d] == nr_of(d) + 1));
        chk("round_idx", nr_of(d), 128'(idx[d]),
            (m_act[d] && m_t[d] <= nr_of(d)) ? 128'(m_t[d]) : 128'(0));
        chk("ciphertext", nr_of(d), ct[d], m_ct[d]);
      end
    end
  end

  task automatic wait_done(input logic chk_state, input logic inject);
    int cyc;
    cyc = 0;
    first[0] = -1;
    first[1] = -1;
    for (int i = 0; i < 16; i++) seq[i] = 4'hf;
    while ((first[0] < 0 || first[1] < 0) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = inject && (cyc == 6);
      pt    = rand128();
      if (cyc < 16) seq[cyc] = idx[0];
      if (vld[0] && first[0] < 0) first[0] = cyc;
      if (vld[1] && first[1] < 0) first[1] = cyc;
      if (chk_state && cyc == 2) chk("init_state", 10, dut10.state_q, APPB_INIT);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    start = 1'b0;
    ack = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!(rdy[0] && rdy[1]) && n < 60);
    chk("drain_to_idle", 10, 128'(rdy[0] && rdy[1]), 128'(1));
    ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    pt    = '0;
    init_sbox();
    expand(0, {APPB_KEY, 128'h0}, 4);
    expand(1, C3_KEY, 8);
    chk("pin_rk10_appB", 10, rk[0][10], APPB_RK10);
    chk("pin_ref_appB", 10, aes_ref(APPB_PT, 0), APPB_CT);
    chk("pin_ref_c3", 14, aes_ref(C1_PT, 1), C3_CT);
    #1 rst_n = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_ready", 10, 128'(rdy[0]), 128'(1));
    chk("reset_ct", 10, ct[0], 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 App. B on NR=10, App. C.3 key on NR=14
    pt = APPB_PT;
    start = 1'b1;
    wait_done(1'b1, 1'b0);
    chk("latency", 10, 128'(first[0]), 128'(12));
    chk("latency", 14, 128'(first[1]), 128'(16));
    chk("appB_ct", 10, ct[0], APPB_CT);

    // Backpressure with a start pulse during DONE
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i == 2);
      pt = rand128();
      chk("bp_valid", 10, 128'(vld[0]), 128'(1));
      chk("bp_ct", 10, ct[0], APPB_CT);
      chk("bp_ready", 10, 128'(rdy[0]), 128'(0));
    end
    start = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    chk("ack_no_accept_ready", 10, 128'(rdy[0]), 128'(1));
    chk("ack_no_accept_busy", 10, 128'(bsy[0]), 128'(0));
    ack = 1'b0;
    @(negedge clk);
    chk("accept_after_ack", 10, 128'(bsy[0]), 128'(1));
    drain();

    // App. C.1 / C.3 with a second start injected mid-round
    expand(0, {C1_KEY, 128'h0}, 4);
    chk("pin_ref_c1", 10, aes_ref(C1_PT, 0), C1_CT);
    @(negedge clk);
    pt = C1_PT;
    start = 1'b1;
    wait_done(1'b0, 1'b1);
    chk("latency_c1", 10, 128'(first[0]), 128'(12));
    chk("latency_c3", 14, 128'(first[1]), 128'(16));
    chk("c1_ct", 10, ct[0], C1_CT);
    chk("c3_ct", 14, ct[1], C3_CT);
    for (int n = 1; n <= 11; n++) chk("idx_sequence", 10, 128'(seq[n]), 128'(n - 1));
    chk("idx_done", 10, 128'(seq[12]), 128'(0));
    drain();

    // Reset mid-round, then a clean rerun
    @(negedge clk);
    pt = C1_PT;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_ready", nr_of(d), 128'(rdy[d]), 128'(1));
      chk("async_rst_busy", nr_of(d), 128'(bsy[d]), 128'(0));
      chk("async_rst_valid", nr_of(d), 128'(vld[d]), 128'(0));
      chk("async_rst_idx", nr_of(d), 128'(idx[d]), 128'(0));
      chk("async_rst_ct", nr_of(d), ct[d], 128'(0));
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pt = C1_PT;
    start = 1'b1;
    wait_done(1'b0, 1'b0);
    chk("rerun_latency", 10, 128'(first[0]), 128'(12));
    chk("rerun_c1_ct", 10, ct[0], C1_CT);
    chk("rerun_c3_ct", 14, ct[1], C3_CT);
    drain();

    // Random keys, plaintexts, start and ack patterns
    for (int it = 0; it < 25; it++) begin
      expand(0, {rand128(), 128'h0}, 4);
      expand(1, {rand128(), rand128()}, 8);
      repeat (80) begin
        start = ($urandom_range(0, 2) == 0);
        ack   = ($urandom_range(0, 1) == 0);
        pt    = rand128();
        @(negedge clk);
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
